id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Registered RV32I decode stage, generalised from the combinational decoder. It sits between if_id and ex and replaces the separate id and id_ex pair with one block. It decodes the full integer ALU set plus LUI, AUIPC and loads into a single output register, with valid/ready handshakes on both sides. It also provides pipeline flush and load-use hazard stalling.

Parameters:
XLEN, 32, data path width; immediates sign-extend to XLEN.
RF_AW, 5, register address width.
NOP_INST, 32'h0000_0013, value driven on inst_o when the output register is empty or reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_addr_i  in  XLEN  PC of incoming instruction
inst_i  in  32  incoming instruction
in_valid_i  in  1  upstream instruction valid
in_ready_o  out  1  stage accepts instruction this cycle
rs1_addr_o  out  RF_AW  regfile read address, inst_i[19:15], combinational
rs2_addr_o  out  RF_AW  regfile read address, inst_i[24:20], combinational
rs1_data_i  in  XLEN  regfile read data 1 (same cycle)
rs2_data_i  in  XLEN  regfile read data 2 (same cycle)
flush_i  in  1  kill contents (branch/jump redirect)
out_valid_o  out  1  output register holds an instruction
out_ready_i  in  1  ex accepts output
inst_addr_o  out  XLEN  registered PC
inst_o  out  32  registered instruction
op_1_o  out  XLEN  operand 1
op_2_o  out  XLEN  operand 2
alu_op_o  out  4  ALU operation code
wd_addr_o  out  RF_AW  destination register
reg_wen_o  out  1  writeback enable
mem_ren_o  out  1  load
illegal_o  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, rst_n=0):
  - out_valid_o=0, inst_o=NOP_INST.
  - inst_addr_o, op_1_o, op_2_o, wd_addr_o, alu_op_o all 0.
  - reg_wen_o=0, mem_ren_o=0, illegal_o=0.
  - Reset mid-operation drops the held instruction.
- Clocking and latency:
  - Accept = in_valid_i & in_ready_o; latency is 1 cycle from accept to out_valid_o.
  - in_ready_o = (~out_valid_o | out_ready_i) & ~hazard, or 1 whenever flush_i=1.
  - Output register holds stable while out_valid_o & ~out_ready_i.
  - Next-state priority: flush_i > accept > consume (out_valid_o & out_ready_i, no accept, so out_valid_o goes to 0) > hold.
  - flush_i=1: out_valid_o=0 next cycle. An instruction presented that cycle is accepted and discarded.
- alu_op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- Decode by opcode:
  - 0010011 OP-IMM: op1=rs1, op2=sext(inst[31:20]).
    - funct3 maps to ADD/SLT/SLTU/XOR/OR/AND.
    - SLLI/SRLI/SRAI use op2=inst[24:20] zero-extended; inst[30] selects SRA.
    - Shift with inst[31:25] not 0000000/0100000 is illegal.
  - 0110011 OP: op1=rs1, op2=rs2; funct3 plus inst[30] maps to the ALU set.
    - funct7 other than 0000000/0100000 (SUB/SRA only) is illegal.
  - 0000011 LOAD: op1=rs1, op2=sext(inst[31:20]), ADD, mem_ren_o=1.
    - funct3 in {000,001,010,100,101} is legal; others are illegal.
  - 0110111 LUI: op1=0, op2={inst[31:12],12'b0} sign-extended to XLEN, PASSB.
  - 0010111 AUIPC: op1=inst_addr_i, op2 as LUI, ADD.
  - Legal instructions: reg_wen_o=(rd!=0), wd_addr_o=rd.
  - Illegal instructions: op1=op2=0, wd_addr_o=0, reg_wen_o=0, mem_ren_o=0, illegal_o=1. Still passed downstream as valid.
- Load-use hazard:
  - hazard = out_valid_o & mem_ren_o & (wd_addr_o!=0) & in_valid_i, AND incoming uses rs1 (OP-IMM/OP/LOAD) with rs1==wd_addr_o, or uses rs2 (OP) with rs2==wd_addr_o.
  - Effect: the dependent instruction waits until the load leaves, then one bubble cycle (out_valid_o=0) follows before it issues.
  - x0 never causes a hazard.
- Empty output register drives inst_o=NOP_INST; other fields keep their last values, qualified by out_valid_o.

Optional Feature:
FWD_EN
- Defined: adds inputs fwd_wen_i (1), fwd_addr_i (RF_AW), fwd_data_i (XLEN) from writeback.
  - When fwd_wen_i & fwd_addr_i!=0 & fwd_addr_i==rs1_addr_o, rs1 operand uses fwd_data_i instead of rs1_data_i.
  - Same rule for rs2.
  - Forwarding is applied before operand muxing.
- Undefined: ports absent, operands come only from regfile data.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid_o=1 -> out_valid_o=0, inst_o=32'h13 immediately (async), all other outputs 0.
- ADDI x3,x1,-5 with rs1_data=10, out_ready=1 -> next cycle op_1_o=10, op_2_o=32'hFFFF_FFFB, alu_op=0, wd_addr=3, reg_wen=1.
- SRAI x5,x6,4 (32'h4043_5293) -> op2=4, alu_op=7; SUB (32'h4020_81B3) -> alu_op=1; funct7=0000001 R-type -> illegal_o=1, reg_wen_o=0.
- Backpressure: out_ready_i=0 for 3 cycles with in_valid=1 -> in_ready_o=0, outputs held stable; release -> next instruction loads in the following cycle.
- Load-use: LW x2,0(x1), then ADD x4,x2,x3 with out_ready=1 -> LW out, one bubble (out_valid_o=0), ADD out on the third cycle; same with ADD x4,x0,x3 -> no bubble.
- Flush: flush_i=1 while holding an instruction and in_valid=1 -> in_ready_o=1, out_valid_o=0 next cycle, flushed instruction never appears downstream. LUI x7,0x12345 -> op2=32'h1234_5000, alu_op=10.

Source files
------------

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_in_if / id_stage_out_if
//  Description : Handshake bundles around the registered decode stage.
//                id_stage_in_if  : fetch -> decode (PC, instruction,
//                                  valid/ready).
//                id_stage_out_if : decode -> execute (decoded operands and
//                                  control, valid/ready).
//                In both bundles the producer takes the master modport and
//                the consumer takes the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================

interface id_stage_in_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] inst_addr_i;
    logic [31:0]     inst_i;
    logic            in_valid_i;
    logic            in_ready_o;

    modport master (output inst_addr_i, inst_i, in_valid_i, input  in_ready_o);
    modport slave  (input  inst_addr_i, inst_i, in_valid_i, output in_ready_o);
endinterface

interface id_stage_out_if #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
);
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  inst_addr_o;
    logic [31:0]      inst_o;
    logic [XLEN-1:0]  op_1_o;
    logic [XLEN-1:0]  op_2_o;
    logic [3:0]       alu_op_o;
    logic [RF_AW-1:0] wd_addr_o;
    logic             reg_wen_o;
    logic             mem_ren_o;
    logic             illegal_o;

    modport master (output out_valid_o, inst_addr_o, inst_o, op_1_o, op_2_o,
                           alu_op_o, wd_addr_o, reg_wen_o, mem_ren_o, illegal_o,
                    input  out_ready_i);
    modport slave  (input  out_valid_o, inst_addr_o, inst_o, op_1_o, op_2_o,
                           alu_op_o, wd_addr_o, reg_wen_o, mem_ren_o, illegal_o,
                    output out_ready_i);
endinterface

`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Registered RV32I decode stage (integer ALU ops, LUI, AUIPC,
//                loads). Decodes the incoming instruction into one output
//                register with valid/ready handshakes on both sides, a flush
//                that kills the held instruction, and load-use hazard
//                stalling.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                up  (slave)     - inst_addr_i, inst_i, in_valid_i, in_ready_o
//                dn  (master)    - out_valid_o, out_ready_i, inst_addr_o,
//                                  inst_o, op_1_o, op_2_o, alu_op_o,
//                                  wd_addr_o, reg_wen_o, mem_ren_o, illegal_o
//                rs1/rs2_addr_o  - regfile read addresses (combinational)
//                rs1/rs2_data_i  - regfile read data (same cycle)
//                flush_i         - kill contents on redirect
//  Options     : FWD_EN - when defined, adds fwd_wen_i / fwd_addr_i /
//                fwd_data_i so a writeback result overrides regfile data.
//  Revision    : 1.0 - initial release
// ============================================================================

module id_stage #(
    parameter int          XLEN     = 32,
    parameter int          RF_AW    = 5,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    id_stage_in_if.slave      up,
    id_stage_out_if.master    dn,
    output logic [RF_AW-1:0]  rs1_addr_o,
    output logic [RF_AW-1:0]  rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
`ifdef FWD_EN
    input  logic              fwd_wen_i,
    input  logic [RF_AW-1:0]  fwd_addr_i,
    input  logic [XLEN-1:0]   fwd_data_i,
`endif
    input  logic              flush_i
);

    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [3:0] c_alu_add   = 4'd0;
    localparam logic [3:0] c_alu_sub   = 4'd1;
    localparam logic [3:0] c_alu_sll   = 4'd2;
    localparam logic [3:0] c_alu_slt   = 4'd3;
    localparam logic [3:0] c_alu_sltu  = 4'd4;
    localparam logic [3:0] c_alu_xor   = 4'd5;
    localparam logic [3:0] c_alu_srl   = 4'd6;
    localparam logic [3:0] c_alu_sra   = 4'd7;
    localparam logic [3:0] c_alu_or    = 4'd8;
    localparam logic [3:0] c_alu_and   = 4'd9;
    localparam logic [3:0] c_alu_passb = 4'd10;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic            w_f7_std;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = up.inst_i[6:0];
    assign w_funct3 = up.inst_i[14:12];
    assign w_funct7 = up.inst_i[31:25];
    assign w_rd     = up.inst_i[11:7];
    assign w_f7_std = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
    assign w_imm_i  = XLEN'($signed(up.inst_i[31:20]));
    assign w_imm_u  = XLEN'($signed({up.inst_i[31:12], 12'b0}));
    assign w_shamt  = XLEN'(up.inst_i[24:20]);

    assign rs1_addr_o = RF_AW'(up.inst_i[19:15]);
    assign rs2_addr_o = RF_AW'(up.inst_i[24:20]);

    // ------------------------------------------------------------------
    // Source operand values (writeback bypass applied before muxing)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

`ifdef FWD_EN
    assign w_rs1_val = (fwd_wen_i && (fwd_addr_i != '0) && (fwd_addr_i == rs1_addr_o))
                       ? fwd_data_i : rs1_data_i;
    assign w_rs2_val = (fwd_wen_i && (fwd_addr_i != '0) && (fwd_addr_i == rs2_addr_o))
                       ? fwd_data_i : rs2_data_i;
`else
    assign w_rs1_val = rs1_data_i;
    assign w_rs2_val = rs2_data_i;
`endif

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic [3:0]       w_alu;
    logic             w_ren;
    logic             w_ill;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic             w_wen;
    logic [RF_AW-1:0] w_wd;

    always_comb begin
        w_op1     = '0;
        w_op2     = '0;
        w_alu     = c_alu_add;
        w_ren     = 1'b0;
        w_ill     = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            c_opc_op_imm: begin
                w_use_rs1 = 1'b1;
                w_op1     = w_rs1_val;
                w_op2     = w_imm_i;
                case (w_funct3)
                    3'b000:  w_alu = c_alu_add;
                    3'b010:  w_alu = c_alu_slt;
                    3'b011:  w_alu = c_alu_sltu;
                    3'b100:  w_alu = c_alu_xor;
                    3'b110:  w_alu = c_alu_or;
                    3'b111:  w_alu = c_alu_and;
                    3'b001: begin
                        w_alu = c_alu_sll;
                        w_op2 = w_shamt;
                        w_ill = ~w_f7_std;
                    end
                    default: begin
                        w_alu = up.inst_i[30] ? c_alu_sra : c_alu_srl;
                        w_op2 = w_shamt;
                        w_ill = ~w_f7_std;
                    end
                endcase
            end
            c_opc_op: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1     = w_rs1_val;
                w_op2     = w_rs2_val;
                case (w_funct3)
                    3'b000:  w_alu = up.inst_i[30] ? c_alu_sub : c_alu_add;
                    3'b001:  w_alu = c_alu_sll;
                    3'b010:  w_alu = c_alu_slt;
                    3'b011:  w_alu = c_alu_sltu;
                    3'b100:  w_alu = c_alu_xor;
                    3'b101:  w_alu = up.inst_i[30] ? c_alu_sra : c_alu_srl;
                    3'b110:  w_alu = c_alu_or;
                    default: w_alu = c_alu_and;
                endcase
                // The alternate funct7 only exists for SUB and SRA.
                w_ill = ~((w_funct7 == 7'b0000000) ||
                          ((w_funct7 == 7'b0100000) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            c_opc_load: begin
                w_use_rs1 = 1'b1;
                w_op1     = w_rs1_val;
                w_op2     = w_imm_i;
                w_ren     = 1'b1;
                w_ill     = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                            (w_funct3 == 3'b111);
            end
            c_opc_lui: begin
                w_op2 = w_imm_u;
                w_alu = c_alu_passb;
            end
            c_opc_auipc: begin
                w_op1 = up.inst_addr_i;
                w_op2 = w_imm_u;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal instructions travel downstream as inert bubbles with a flag.
        if (w_ill) begin
            w_op1 = '0;
            w_op2 = '0;
            w_ren = 1'b0;
        end
    end

    assign w_wen = ~w_ill && (w_rd != 5'd0);
    assign w_wd  = w_ill ? '0 : RF_AW'(w_rd);

    // ------------------------------------------------------------------
    // Handshake and load-use hazard
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [31:0]      r_inst;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [3:0]       r_alu;
    logic [RF_AW-1:0] r_wd;
    logic             r_wen;
    logic             r_ren;
    logic             r_ill;

    logic w_hazard;
    logic w_accept;

    // A load in the output register cannot feed the next instruction;
    // holding the consumer back until the load leaves yields one bubble.
    assign w_hazard = r_valid && r_ren && (r_wd != '0) && up.in_valid_i &&
                      ((w_use_rs1 && (rs1_addr_o == r_wd)) ||
                       (w_use_rs2 && (rs2_addr_o == r_wd)));

    assign up.in_ready_o = flush_i || ((~r_valid || dn.out_ready_i) && ~w_hazard);
    assign w_accept      = up.in_valid_i && up.in_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_op1   <= '0;
            r_op2   <= '0;
            r_alu   <= c_alu_add;
            r_wd    <= '0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (flush_i) begin
            // Anything accepted during a flush belongs to the killed path.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pc    <= up.inst_addr_i;
            r_inst  <= up.inst_i;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_alu   <= w_alu;
            r_wd    <= w_wd;
            r_wen   <= w_wen;
            r_ren   <= w_ren;
            r_ill   <= w_ill;
        end else if (r_valid && dn.out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign dn.out_valid_o = r_valid;
    assign dn.inst_addr_o = r_pc;
    assign dn.inst_o      = r_valid ? r_inst : NOP_INST;
    assign dn.op_1_o      = r_op1;
    assign dn.op_2_o      = r_op2;
    assign dn.alu_op_o    = r_alu;
    assign dn.wd_addr_o   = r_wd;
    assign dn.reg_wen_o   = r_wen;
    assign dn.mem_ren_o   = r_ren;
    assign dn.illegal_o   = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage. Directed scenarios followed
//                by randomized traffic, all compared against a behavioural
//                model of the decode rules and the stage occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_id_stage;

    localparam int          XLEN  = 32;
    localparam int          RF_AW = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_i = 1'b0;
    logic [RF_AW-1:0] rs1_addr_o;
    logic [RF_AW-1:0] rs2_addr_o;
    logic [XLEN-1:0]  rs1_data_i = '0;
    logic [XLEN-1:0]  rs2_data_i = '0;

    id_stage_in_if  #(.XLEN(XLEN))                up ();
    id_stage_out_if #(.XLEN(XLEN), .RF_AW(RF_AW)) dn ();

    id_stage #(.XLEN(XLEN), .RF_AW(RF_AW), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up         (up),
        .dn         (dn),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        int          alu;
        int          wd;
        bit          wen;
        bit          ren;
        bit          ill;
        bit          u1;
        bit          u2;
    } dec_t;

    bit          m_valid;
    dec_t        m_dec;
    logic [31:0] m_inst;
    logic [31:0] m_pc;

    // ALU code per funct3; the alternate encoding (SUB/SRA) is base + 1.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b);
        dec_t d;
        int   base [8];
        int   opc, f3, f7, rd, immi;
        logic [31:0] uimm;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc  = int'(ins[6:0]);
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        rd   = int'(ins[11:7]);
        immi = int'(ins[31:20]);
        if (immi >= 2048) immi -= 4096;
        uimm = ins & 32'hFFFF_F000;
        d = '{op1: 0, op2: 0, alu: 0, wd: 0, wen: 0, ren: 0, ill: 0, u1: 0, u2: 0};
        d.u1 = (opc == 'h13) || (opc == 'h33) || (opc == 'h03);
        d.u2 = (opc == 'h33);
        case (opc)
            'h13: begin
                d.op1 = a;
                d.op2 = 32'(immi);
                d.alu = base[f3] + ((f3 == 5 && ins[30]) ? 1 : 0);
                if (f3 == 1 || f3 == 5) begin
                    d.op2 = 32'(int'(ins[24:20]));
                    d.ill = !(f7 == 0 || f7 == 32);
                end
            end
            'h33: begin
                d.op1 = a;
                d.op2 = b;
                d.alu = base[f3] + ((f7 == 32) ? 1 : 0);
                d.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            'h03: begin
                d.op1 = a;
                d.op2 = 32'(immi);
                d.ren = 1;
                d.ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            'h37: begin d.op2 = uimm; d.alu = 10; end
            'h17: begin d.op1 = pc; d.op2 = uimm; end
            default: d.ill = 1;
        endcase
        if (d.ill) begin
            d.op1 = 0; d.op2 = 0; d.ren = 0; d.wen = 0; d.wd = 0;
        end else begin
            d.wd  = rd;
            d.wen = (rd != 0);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_inst  = NOP;
        m_pc    = 0;
        m_dec   = '{op1: 0, op2: 0, alu: 0, wd: 0, wen: 0, ren: 0, ill: 0, u1: 0, u2: 0};
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(dn.out_valid_o), 32'(m_valid));
        chk("inst_o", dn.inst_o, m_valid ? m_inst : NOP);
        if (m_valid) begin
            chk("inst_addr", dn.inst_addr_o, m_pc);
            chk("op_1", dn.op_1_o, m_dec.op1);
            chk("op_2", dn.op_2_o, m_dec.op2);
            chk("wd_addr", 32'(dn.wd_addr_o), 32'(m_dec.wd));
            chk("reg_wen", 32'(dn.reg_wen_o), 32'(m_dec.wen));
            chk("mem_ren", 32'(dn.mem_ren_o), 32'(m_dec.ren));
            chk("illegal", 32'(dn.illegal_o), 32'(m_dec.ill));
            if (!m_dec.ill) chk("alu_op", 32'(dn.alu_op_o), 32'(m_dec.alu));
        end
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(dn.out_valid_o), 32'd0);
        chk("rst_inst", dn.inst_o, NOP);
        chk("rst_addr", dn.inst_addr_o, 32'd0);
        chk("rst_op1", dn.op_1_o, 32'd0);
        chk("rst_op2", dn.op_2_o, 32'd0);
        chk("rst_alu", 32'(dn.alu_op_o), 32'd0);
        chk("rst_wd", 32'(dn.wd_addr_o), 32'd0);
        chk("rst_flags", {29'd0, dn.reg_wen_o, dn.mem_ren_o, dn.illegal_o}, 32'd0);
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at posedge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit fl, input bit rdy);
        dec_t d;
        bit   haz, exp_rdy;
        @(negedge clk);
        up.in_valid_i   = v;
        up.inst_i       = ins;
        up.inst_addr_i  = pc;
        rs1_data_i      = a;
        rs2_data_i      = b;
        flush_i         = fl;
        dn.out_ready_i  = rdy;
        #1;
        d   = ref_decode(ins, pc, a, b);
        haz = m_valid && m_dec.ren && (m_dec.wd != 0) && v &&
              ((d.u1 && int'(ins[19:15]) == m_dec.wd) ||
               (d.u2 && int'(ins[24:20]) == m_dec.wd));
        exp_rdy = fl || ((!m_valid || rdy) && !haz);
        chk("in_ready", 32'(up.in_ready_o), 32'(exp_rdy));
        chk("rs1_addr", 32'(rs1_addr_o), 32'(ins[19:15]));
        chk("rs2_addr", 32'(rs2_addr_o), 32'(ins[24:20]));
        @(posedge clk);
        if (fl)                    m_valid = 0;
        else if (v && exp_rdy)     begin m_valid = 1; m_dec = d; m_inst = ins; m_pc = pc; end
        else if (m_valid && rdy)   m_valid = 0;
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r, t;
        int          k;
        r = $urandom;
        t = $urandom;
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        r[11:7]  = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    r[6:0] = 7'h13;
            2, 3:    r[6:0] = 7'h33;
            4, 5, 6: r[6:0] = 7'h03;
            7:       r[6:0] = 7'h37;
            8:       r[6:0] = 7'h17;
            default: r[6:0] = t[6:0];
        endcase
        k = $urandom_range(0, 3);
        if (k == 0)      r[31:25] = 7'h00;
        else if (k == 1) r[31:25] = 7'h20;
        else if (k == 2) r[31:25] = 7'h01;
        return r;
    endfunction

    localparam logic [31:0] I_ADDI  = 32'hFFB0_8193; // addi x3,x1,-5
    localparam logic [31:0] I_SRAI  = 32'h4043_5293; // srai x5,x6,4
    localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub  x3,x1,x2
    localparam logic [31:0] I_BADR  = 32'h0220_81B3; // funct7=0000001
    localparam logic [31:0] I_LUI   = 32'h1234_53B7; // lui  x7,0x12345
    localparam logic [31:0] I_LW    = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADDD  = 32'h0031_0233; // add  x4,x2,x3
    localparam logic [31:0] I_ADD0  = 32'h0030_0233; // add  x4,x0,x3

    initial begin
        up.in_valid_i  = 1'b0;
        up.inst_i      = NOP;
        up.inst_addr_i = '0;
        dn.out_ready_i = 1'b1;
        model_reset();
        #12;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Decode of individual instruction types
        step(1, I_ADDI, 32'h100, 32'd10, 32'd0, 0, 1);
        chk("addi_op1", dn.op_1_o, 32'd10);
        chk("addi_op2", dn.op_2_o, 32'hFFFF_FFFB);
        chk("addi_alu", 32'(dn.alu_op_o), 32'd0);
        chk("addi_wd", 32'(dn.wd_addr_o), 32'd3);
        chk("addi_wen", 32'(dn.reg_wen_o), 32'd1);
        step(1, I_SRAI, 32'h104, 32'h8000_0000, 32'd0, 0, 1);
        chk("srai_op2", dn.op_2_o, 32'd4);
        chk("srai_alu", 32'(dn.alu_op_o), 32'd7);
        step(1, I_SUB, 32'h108, 32'd7, 32'd9, 0, 1);
        chk("sub_alu", 32'(dn.alu_op_o), 32'd1);
        step(1, I_BADR, 32'h10C, 32'd7, 32'd9, 0, 1);
        chk("badr_ill", 32'(dn.illegal_o), 32'd1);
        chk("badr_wen", 32'(dn.reg_wen_o), 32'd0);
        step(1, I_LUI, 32'h110, 32'd1, 32'd2, 0, 1);
        chk("lui_op2", dn.op_2_o, 32'h1234_5000);
        chk("lui_alu", 32'(dn.alu_op_o), 32'd10);

        // Backpressure: LUI stays put for three cycles, then ADDI loads
        for (int i = 0; i < 3; i++) begin
            step(1, I_ADDI, 32'h114, 32'd5, 32'd0, 0, 0);
            chk("bp_hold_op2", dn.op_2_o, 32'h1234_5000);
        end
        step(1, I_ADDI, 32'h114, 32'd5, 32'd0, 0, 1);
        chk("bp_release_op1", dn.op_1_o, 32'd5);

        // Load-use: one bubble between LW and dependent ADD
        step(1, I_LW, 32'h200, 32'h40, 32'd0, 0, 1);
        chk("lu_ren", 32'(dn.mem_ren_o), 32'd1);
        step(1, I_ADDD, 32'h204, 32'd1, 32'd2, 0, 1);
        chk("lu_bubble", 32'(dn.out_valid_o), 32'd0);
        step(1, I_ADDD, 32'h204, 32'd1, 32'd2, 0, 1);
        chk("lu_issue", 32'(dn.out_valid_o), 32'd1);
        step(1, I_LW, 32'h208, 32'h40, 32'd0, 0, 1);
        step(1, I_ADD0, 32'h20C, 32'd0, 32'd3, 0, 1);
        chk("nohaz_valid", 32'(dn.out_valid_o), 32'd1);
        chk("nohaz_wd", 32'(dn.wd_addr_o), 32'd4);

        // Flush while holding
        step(1, I_ADDI, 32'h300, 32'd1, 32'd0, 0, 0);
        step(1, I_SUB, 32'h304, 32'd1, 32'd2, 1, 0);
        chk("flush_empty", 32'(dn.out_valid_o), 32'd0);
        step(0, I_SUB, 32'h304, 32'd1, 32'd2, 0, 1);
        chk("flush_gone", 32'(dn.out_valid_o), 32'd0);

        // Asynchronous reset with an instruction held
        step(1, I_ADDI, 32'h400, 32'd1, 32'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
                 $urandom, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
